fft_readout_ctrl: RTL and testbench
===================================

FFT_READOUT_CTRL -- requirements
Module: fft_readout_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: width of the RAM address and sample index.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of each real or imaginary half.
REQ-003 SHALL have parameter DEPTH, default 16: number of samples per frame.
REQ-004 SHALL have parameter BIT_REV, default 1: 1 = reverse the address bits, 0 = use natural address order.
REQ-005 SHALL have one clock and asynchronous active-low reset: clk input 1 (rising edge), then rst_n input 1.
REQ-006 SHALL have port start, input, 1 bit: frame readout request pulse.
REQ-007 SHALL have port abort, input, 1 bit: cancels the frame in progress.
REQ-008 SHALL have port ram_addr, output, ADDR_WIDTH bits: RAM read address.
REQ-009 SHALL have port ram_re, output, 1 bit: RAM read enable.
REQ-010 SHALL have port ram_data, input, 2*DATA_WIDTH bits: RAM read data {re, im}, valid one cycle after ram_re.
REQ-011 SHALL have port out_data, output, 2*DATA_WIDTH bits: the sample presented downstream.
REQ-012 SHALL have port out_index, output, ADDR_WIDTH bits: natural-order index of out_data.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_last (output, 1): valid/ready stream, with out_last marking index DEPTH-1.
REQ-014 SHALL have ports busy (output, 1) and done (output, 1): busy is high while a frame is active; done is a 1-cycle pulse when a frame completes.

Function
REQ-015 SHALL implement states IDLE, ISSUE, CAPTURE and HOLD.
REQ-016 IDLE: start=1 SHALL clear idx to 0 and move to ISSUE on the next edge; start=0 SHALL keep the block in IDLE.
REQ-017 ISSUE SHALL drive ram_re=1 and ram_addr=map(idx) for exactly one cycle, then move to CAPTURE.
REQ-018 map(idx) SHALL be the ADDR_WIDTH-bit reversal of idx when BIT_REV=1, and idx when BIT_REV=0.
REQ-019 CAPTURE SHALL register ram_data into out_data and idx into out_index, and SHALL set out_valid=1 from the next cycle; the state then moves to HOLD.
REQ-020 HOLD SHALL keep out_data, out_index and out_last stable while out_valid=1 and out_ready=0.
REQ-021 A transfer occurs when out_valid=1 and out_ready=1 on the same edge.
REQ-022 On a transfer, out_valid SHALL clear; if idx=DEPTH-1, done SHALL pulse for the next cycle and the state returns to IDLE; otherwise idx increments and the state moves to ISSUE.
REQ-023 Minimum throughput SHALL be 1 sample per 3 cycles; start-to-first-out_valid latency SHALL be 3 cycles.
REQ-024 In every state other than ISSUE, ram_re SHALL be 0 and ram_addr SHALL be 0.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 abort=1 in any state SHALL, on the next edge, return the block to IDLE with out_valid=0 and busy=0, without pulsing done; abort takes priority over start and over a transfer.
REQ-027 busy SHALL be 1 in ISSUE, CAPTURE and HOLD, and 0 in IDLE.
REQ-028 out_last SHALL equal (out_index==DEPTH-1) while out_valid=1, and 0 otherwise.
REQ-029 idx SHALL never wrap; counting stops at DEPTH-1.

Reset
REQ-030 rst_n=0 SHALL, asynchronously: set the state to IDLE; set idx, out_data, out_index, ram_addr, ram_re, out_valid, out_last, busy and done to 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL wait for a new start.

Structure
REQ-032 Package fft_pkg SHALL hold the default ADDR_WIDTH, DATA_WIDTH and DEPTH values and the state encoding constants.
REQ-033 Address reversal SHALL be a separate combinational sub-module, addr_bitrev.

Verification
REQ-034 Scenario, reset and idle: hold rst_n=0 and pulse start -> all outputs 0; no ram_re.
REQ-035 Scenario, BIT_REV=1 with out_ready held 1: RAM word k = {k, ~k}, start pulsed -> ram_addr sequence 0,8,4,12,2,...,15; out_index sequence 0..15; 16 transfers at a 3-cycle spacing; out_last on index 15; done 1 cycle after the last transfer.
REQ-036 Scenario, backpressure: out_ready=0 for 5 cycles on index 3 -> out_data and out_index stay stable; no ram_re pulse until the transfer.
REQ-037 Scenario, start while busy: extra start pulses during a frame -> exactly 16 transfers and one done.
REQ-038 Scenario, abort during HOLD on index 7 -> out_valid=0 and busy=0 the next cycle; no done; a new start begins again at index 0.
REQ-039 Scenario, rst_n=0 during CAPTURE -> outputs clear immediately without waiting for a clock edge; a subsequent frame completes normally.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared defaults and FSM state encoding for the FFT readout
//               controller (fft_readout_ctrl) and its address helpers.
// Contents    : FFT_ADDR_WIDTH, FFT_DATA_WIDTH, FFT_DEPTH default values;
//               state_t encoding (IDLE, ISSUE, CAPTURE, HOLD).
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_ADDR_WIDTH = 4;
    localparam int FFT_DATA_WIDTH = 16;
    localparam int FFT_DEPTH      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/addr_bitrev.sv
`default_nettype none
// ============================================================================
// Module      : addr_bitrev
// Description : Purely combinational bit reversal of an address word.
//               Used to read an FFT result RAM written in bit-reversed order.
// Ports       : addr_in  [WIDTH-1:0] - natural-order address
//               addr_out [WIDTH-1:0] - addr_in with its bit order reversed
// Revision    : 1.0 - initial release
// ============================================================================
module addr_bitrev #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] addr_in,
    output logic [WIDTH-1:0] addr_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign addr_out[i] = addr_in[WIDTH-1-i];
    end

endmodule : addr_bitrev
`default_nettype wire

// File: rtl/fft_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_readout_ctrl
// Description : Reads one FFT frame of DEPTH samples out of a result RAM
//               (optionally in bit-reversed address order) and presents the
//               samples in natural index order on a valid/ready stream.
//               One sample is fetched per ISSUE -> CAPTURE -> HOLD round,
//               giving at best one sample every 3 cycles.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               start, abort          - frame request / cancel
//               ram_addr, ram_re      - RAM read port (data returns 1 cycle later)
//               ram_data              - RAM read data {re, im}
//               out_data, out_index   - sample and its natural-order index
//               out_valid, out_ready  - stream handshake
//               out_last              - marks index DEPTH-1
//               busy, done            - frame active / 1-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module fft_readout_ctrl
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH = FFT_ADDR_WIDTH,
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int DEPTH      = FFT_DEPTH,
    parameter int BIT_REV    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic                    ram_re,
    input  logic [2*DATA_WIDTH-1:0] ram_data,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]   out_index,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [ADDR_WIDTH-1:0]   mapped_addr;
    logic                    xfer;
    logic                    at_last;

    assign xfer    = out_valid && out_ready;
    assign at_last = (idx == LAST_IDX);

    // Address mapping: bit-reversed or natural order, fixed at elaboration.
    if (BIT_REV != 0) begin : g_bitrev
        addr_bitrev #(
            .WIDTH    (ADDR_WIDTH)
        ) u_addr_bitrev (
            .addr_in  (idx),
            .addr_out (mapped_addr)
        );
    end else begin : g_natural
        assign mapped_addr = idx;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and RAM-side outputs. The RAM port is only ever driven in
    // ISSUE, so ram_addr is forced to zero everywhere else.
    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        ram_addr  = '0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                ram_re    = 1'b1;
                ram_addr  = mapped_addr;
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (xfer) state_nxt = at_last ? ST_IDLE : ST_ISSUE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Abort wins over start and over a pending transfer.
        if (abort) state_nxt = ST_IDLE;
    end

    // Datapath: sample index, output register and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                out_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) idx <= '0;
                    end
                    ST_CAPTURE: begin
                        out_data  <= ram_data;
                        out_index <= idx;
                        out_valid <= 1'b1;
                    end
                    ST_HOLD: begin
                        if (xfer) begin
                            out_valid <= 1'b0;
                            // idx stops at the last sample instead of wrapping.
                            if (at_last) done <= 1'b1;
                            else         idx  <= idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_last = out_valid && (out_index == LAST_IDX);

endmodule : fft_readout_ctrl
`default_nettype wire

// File: tb/tb_fft_readout_ctrl.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_fft_readout_ctrl
// Description : Directed self-checking bench for fft_readout_ctrl
//               (ADDR_WIDTH=4, DATA_WIDTH=16, DEPTH=16, BIT_REV=1).
//               RAM word at address a is {a, ~a}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_readout_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, out_ready;
    logic [AW-1:0] ram_addr, out_index;
    logic          ram_re, out_valid, out_last, busy, done;
    logic [2*DW-1:0] ram_data = '0;
    logic [2*DW-1:0] out_data;

    always #5 clk = ~clk;

    fft_readout_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .BIT_REV    (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_data  (ram_data),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // RAM model: one-cycle read latency, word a = {a, ~a}
    always @(posedge clk) begin
        if (ram_re) ram_data <= {DW'(ram_addr), ~DW'(ram_addr)};
    end

    function automatic logic [2*DW-1:0] word_of(input int a);
        logic [DW-1:0] t;
        t = DW'(a);
        return {t, ~t};
    endfunction

    int rev_tbl [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor state (sampled on the falling edge)
    int cyc = 0;
    int n_re, n_xfer, n_done, bad_addr, bad_last, start_cyc, first_valid_cyc, done_cyc;
    int re_addr [64];
    int x_idx   [64];
    int x_cyc   [64];
    logic [2*DW-1:0] x_data [64];
    logic x_last [64];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (start && start_cyc < 0) start_cyc = cyc;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (ram_re) begin
                if (n_re < 64) re_addr[n_re] = int'(ram_addr);
                n_re++;
            end else if (ram_addr != '0) begin
                bad_addr++;
            end
            if (out_valid && out_ready) begin
                if (n_xfer < 64) begin
                    x_idx[n_xfer]  = int'(out_index);
                    x_data[n_xfer] = out_data;
                    x_cyc[n_xfer]  = cyc;
                    x_last[n_xfer] = out_last;
                end
                n_xfer++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (out_last !== (out_valid && out_index == AW'(DEPTH - 1))) bad_last++;
        end
    end

    task automatic clear_logs();
        n_re = 0; n_xfer = 0; n_done = 0; bad_addr = 0; bad_last = 0;
        start_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (n_done == 0) begin
            n_bad++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        int seen = 0;
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            tick();
            if (ram_re || busy) seen++;
        end
        start = 1'b0;
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL reset_no_re: got %0d active cycles, want 0", seen); end
        n_cmp++; if (ram_re !== 1'b0) begin n_bad++; $display("FAIL reset_ram_re: got %b want 0", ram_re); end
        n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL reset_ram_addr: got %0h want 0", ram_addr); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        n_cmp++; if (out_index !== '0) begin n_bad++; $display("FAIL reset_out_index: got %0h want 0", out_index); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        clear_logs();
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b0 || n_re != 0) begin n_bad++; $display("FAIL idle_after_reset: busy=%b re_count=%0d want 0/0", busy, n_re); end
    endtask

    task automatic test_bitrev_stream();
        clear_logs();
        out_ready = 1'b1;
        pulse_start();
        wait_done(120, "stream_done");
        repeat (3) tick();
        n_cmp++; if (n_re != 16) begin n_bad++; $display("FAIL stream_re_count: got %0d want 16", n_re); end
        n_cmp++; if (n_xfer != 16) begin n_bad++; $display("FAIL stream_xfer_count: got %0d want 16", n_xfer); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (re_addr[k] != rev_tbl[k]) begin n_bad++; $display("FAIL stream_addr[%0d]: got %0d want %0d", k, re_addr[k], rev_tbl[k]); end
            n_cmp++; if (x_idx[k] != k) begin n_bad++; $display("FAIL stream_index[%0d]: got %0d want %0d", k, x_idx[k], k); end
            n_cmp++; if (x_data[k] !== word_of(rev_tbl[k])) begin n_bad++; $display("FAIL stream_data[%0d]: got %0h want %0h", k, x_data[k], word_of(rev_tbl[k])); end
            n_cmp++; if (x_last[k] !== (k == 15)) begin n_bad++; $display("FAIL stream_last[%0d]: got %b want %b", k, x_last[k], (k == 15)); end
            if (k > 0) begin
                n_cmp++; if (x_cyc[k] - x_cyc[k-1] != 3) begin n_bad++; $display("FAIL stream_spacing[%0d]: got %0d want 3", k, x_cyc[k] - x_cyc[k-1]); end
            end
        end
        n_cmp++; if (first_valid_cyc - start_cyc != 3) begin n_bad++; $display("FAIL stream_latency: got %0d want 3", first_valid_cyc - start_cyc); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL stream_done_count: got %0d want 1", n_done); end
        n_cmp++; if (done_cyc - x_cyc[15] != 1) begin n_bad++; $display("FAIL stream_done_timing: got %0d want 1", done_cyc - x_cyc[15]); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stream_busy_end: got %b want 0", busy); end
        n_cmp++; if (bad_addr != 0) begin n_bad++; $display("FAIL stream_addr_idle: got %0d nonzero-address cycles want 0", bad_addr); end
        n_cmp++; if (bad_last != 0) begin n_bad++; $display("FAIL stream_last_flag: got %0d bad cycles want 0", bad_last); end
    endtask

    task automatic test_backpressure();
        int found = 0;
        int unstable = 0;
        int re0;
        logic [2*DW-1:0] d0;
        logic [AW-1:0] i0;
        clear_logs();
        out_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 100 && found == 0; k++) begin
            tick();
            if (out_valid && out_index == 4'd3) begin
                out_ready = 1'b0;
                found = 1;
            end
        end
        n_cmp++; if (found != 1) begin n_bad++; $display("FAIL bp_reach_idx3: got %0d want 1", found); end
        d0 = out_data; i0 = out_index; re0 = n_re;
        repeat (5) begin
            tick();
            if (out_data !== d0 || out_index !== i0 || out_valid !== 1'b1) unstable++;
        end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
        n_cmp++; if (n_re != re0) begin n_bad++; $display("FAIL bp_no_re: got %0d reads want %0d", n_re, re0); end
        n_cmp++; if (d0 !== word_of(12)) begin n_bad++; $display("FAIL bp_data: got %0h want %0h", d0, word_of(12)); end
        out_ready = 1'b1;
        wait_done(120, "bp_done");
        repeat (2) tick();
        n_cmp++; if (n_xfer != 16) begin n_bad++; $display("FAIL bp_xfer_count: got %0d want 16", n_xfer); end
        n_cmp++; if (x_idx[3] != 3) begin n_bad++; $display("FAIL bp_xfer_index: got %0d want 3", x_idx[3]); end
        n_cmp++; if (x_cyc[3] - x_cyc[2] != 8) begin n_bad++; $display("FAIL bp_stall_len: got %0d want 8", x_cyc[3] - x_cyc[2]); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL bp_done_count: got %0d want 1", n_done); end
    endtask

    task automatic test_start_while_busy();
        clear_logs();
        out_ready = 1'b1;
        pulse_start();
        repeat (4) tick();
        pulse_start();
        repeat (10) tick();
        pulse_start();
        repeat (20) tick();
        pulse_start();
        wait_done(120, "swb_done");
        repeat (10) tick();
        n_cmp++; if (n_xfer != 16) begin n_bad++; $display("FAIL swb_xfer_count: got %0d want 16", n_xfer); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL swb_done_count: got %0d want 1", n_done); end
        n_cmp++; if (n_re != 16) begin n_bad++; $display("FAIL swb_re_count: got %0d want 16", n_re); end
        n_cmp++; if (x_idx[15] != 15) begin n_bad++; $display("FAIL swb_last_index: got %0d want 15", x_idx[15]); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL swb_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_abort();
        int found = 0;
        clear_logs();
        out_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 100 && found == 0; k++) begin
            tick();
            if (out_valid && out_index == 4'd7) begin
                out_ready = 1'b0;
                found = 1;
            end
        end
        n_cmp++; if (found != 1) begin n_bad++; $display("FAIL abort_reach_idx7: got %0d want 1", found); end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL abort_out_last: got %b want 0", out_last); end
        out_ready = 1'b1;
        repeat (5) tick();
        n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
        n_cmp++; if (n_xfer != 7) begin n_bad++; $display("FAIL abort_xfer_count: got %0d want 7", n_xfer); end
        n_cmp++; if (n_re != 8) begin n_bad++; $display("FAIL abort_re_count: got %0d want 8", n_re); end
        clear_logs();
        pulse_start();
        wait_done(120, "abort_restart_done");
        repeat (2) tick();
        n_cmp++; if (x_idx[0] != 0) begin n_bad++; $display("FAIL abort_restart_index: got %0d want 0", x_idx[0]); end
        n_cmp++; if (n_xfer != 16) begin n_bad++; $display("FAIL abort_restart_xfers: got %0d want 16", n_xfer); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL abort_restart_done_count: got %0d want 1", n_done); end
    endtask

    task automatic test_reset_capture();
        int found = 0;
        clear_logs();
        out_ready = 1'b1;
        pulse_start();
        // Address 10 is the bit-reversed read of index 5.
        for (int k = 0; k < 100 && found == 0; k++) begin
            tick();
            if (ram_re && ram_addr == 4'd10) found = 1;
        end
        n_cmp++; if (found != 1) begin n_bad++; $display("FAIL rstcap_reach_idx5: got %0d want 1", found); end
        tick();
        #2;
        n_cmp++; if (busy !== 1'b1 || out_data !== word_of(2)) begin n_bad++; $display("FAIL rstcap_pre: busy=%b data=%0h want 1/%0h", busy, out_data, word_of(2)); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstcap_busy: got %b want 0", busy); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rstcap_out_data: got %0h want 0", out_data); end
        n_cmp++; if (out_index !== '0) begin n_bad++; $display("FAIL rstcap_out_index: got %0h want 0", out_index); end
        n_cmp++; if (out_valid !== 1'b0 || ram_re !== 1'b0) begin n_bad++; $display("FAIL rstcap_valid_re: got %b/%b want 0/0", out_valid, ram_re); end
        repeat (2) tick();
        rst_n = 1'b1;
        clear_logs();
        repeat (5) tick();
        n_cmp++; if (n_re != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstcap_wait_start: reads=%0d busy=%b want 0/0", n_re, busy); end
        pulse_start();
        wait_done(120, "rstcap_done");
        repeat (2) tick();
        n_cmp++; if (n_xfer != 16) begin n_bad++; $display("FAIL rstcap_xfers: got %0d want 16", n_xfer); end
        n_cmp++; if (x_data[0] !== word_of(0) || x_idx[15] != 15) begin n_bad++; $display("FAIL rstcap_frame: data0=%0h idx15=%0d want %0h/15", x_data[0], x_idx[15], word_of(0)); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL rstcap_done_count: got %0d want 1", n_done); end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_bitrev_stream();
        test_backpressure();
        test_start_while_busy();
        test_abort();
        test_reset_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fft_readout_ctrl
`default_nettype wire
